// File: rtl/step_move_ctrl.sv
// Trapezoidal-profile step sequencer: accepts a move command and emits step strobes
// through accelerate / cruise / decelerate phases. Optional macro STEP_POS_TRACK_EN adds a position counter.
module step_move_ctrl #(
   parameter int               CNT_W        = 24,
   parameter int               STEPS_W      = 16,
   parameter logic [CNT_W-1:0] START_PERIOD = 24'd400000,
   parameter logic [CNT_W-1:0] MIN_PERIOD   = 24'd100000,
   parameter logic [CNT_W-1:0] ACCEL_STEP   = 24'd10000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               dir_in,
   input  logic [STEPS_W-1:0] steps_in,
   input  logic               abort,
   output logic               step_pulse,
   output logic               dir_out,
   output logic               busy,
   output logic               done,
   output logic [STEPS_W-1:0] steps_left,
   output logic [CNT_W-1:0]   cur_period
`ifdef STEP_POS_TRACK_EN
   ,
   input  logic               zero_pos,
   output logic signed [31:0] position
`endif
);

   typedef enum logic [2:0] {S_IDLE, S_ACCEL, S_CRUISE, S_DECEL, S_FIN} state_t;

   state_t               state, state_d;
   logic [CNT_W-1:0]     timer, timer_d, period_d;
   logic [STEPS_W-1:0]   ramp_cnt, ramp_d, left_d, l_new;
   logic                 dir_d, busy_d, pulse_d, done_d, fire;
   logic [CNT_W:0]       dec_sum;

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_d  = state;
      timer_d  = timer;
      period_d = cur_period;
      ramp_d   = ramp_cnt;
      left_d   = steps_left;
      dir_d    = dir_out;
      busy_d   = busy;
      pulse_d  = 1'b0;
      done_d   = 1'b0;
      l_new    = steps_left;
      dec_sum  = {1'b0, cur_period} + {1'b0, ACCEL_STEP};
      fire     = ({1'b0, timer} + (CNT_W+1)'(1)) >= {1'b0, cur_period};

      case (state)
         S_IDLE: begin
            if (start && !abort) begin
               if (steps_in != '0) begin
                  dir_d    = dir_in;
                  left_d   = steps_in;
                  period_d = START_PERIOD;
                  timer_d  = '0;
                  ramp_d   = '0;
                  busy_d   = 1'b1;
                  state_d  = S_ACCEL;
               end else begin
                  state_d = S_FIN;
               end
            end
         end
         S_ACCEL, S_CRUISE, S_DECEL: begin
            timer_d = timer + CNT_W'(1);
            if (fire) begin
               pulse_d = 1'b1;
               timer_d = '0;
               l_new   = (steps_left != '0) ? steps_left - STEPS_W'(1) : '0;
               left_d  = l_new;
               if (l_new == '0) begin
                  state_d = S_FIN;
               end else if (state == S_ACCEL && l_new > ramp_cnt) begin
                  ramp_d = ramp_cnt + STEPS_W'(1);
                  // Compare before subtracting so a small period can never wrap.
                  if ({1'b0, cur_period} <= {1'b0, MIN_PERIOD} + {1'b0, ACCEL_STEP}) begin
                     period_d = MIN_PERIOD;
                     state_d  = S_CRUISE;
                  end else begin
                     period_d = cur_period - ACCEL_STEP;
                  end
               end else if (!(state == S_CRUISE && l_new > ramp_cnt)) begin
                  period_d = (dec_sum >= {1'b0, START_PERIOD}) ? START_PERIOD : dec_sum[CNT_W-1:0];
                  ramp_d   = (ramp_cnt != '0) ? ramp_cnt - STEPS_W'(1) : '0;
                  state_d  = S_DECEL;
               end
            end
            // Abort trims the remaining steps to what the down-ramp needs; the running interval completes.
            if (abort && state_d != S_FIN) begin
               if ({1'b0, left_d} > {1'b0, ramp_d} + (STEPS_W+1)'(1))
                  left_d = ramp_d + STEPS_W'(1);
               state_d = S_DECEL;
            end
         end
         S_FIN: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: registered state uses non-blocking assignments only, so all flops update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         timer      <= '0;
         ramp_cnt   <= '0;
         cur_period <= START_PERIOD;
         steps_left <= '0;
         dir_out    <= 1'b0;
         busy       <= 1'b0;
         step_pulse <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_d;
         timer      <= timer_d;
         ramp_cnt   <= ramp_d;
         cur_period <= period_d;
         steps_left <= left_d;
         dir_out    <= dir_d;
         busy       <= busy_d;
         step_pulse <= pulse_d;
         done       <= done_d;
      end
   end

`ifdef STEP_POS_TRACK_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         position <= '0;
      else if (zero_pos)
         position <= '0;
      else if (step_pulse)
         position <= dir_out ? position + 32'sd1 : position - 32'sd1;
   end
`endif

endmodule

// File: tb/tb_step_move_ctrl.sv
// Self-checking bench for step_move_ctrl: directed profile cases plus randomized moves
// compared against a step-level reference model of the speed profile.
module tb_step_move_ctrl;

   localparam int SP = 20;
   localparam int MP = 8;
   localparam int AS = 4;

   logic        clk, rst, start, dir_in, abort;
   logic [15:0] steps_in;
   logic        step_pulse, dir_out, busy, done;
   logic [15:0] steps_left;
   logic [23:0] cur_period;
`ifdef STEP_POS_TRACK_EN
   logic               zero_pos;
   logic signed [31:0] position;
`endif

   step_move_ctrl #(
      .CNT_W(24), .STEPS_W(16),
      .START_PERIOD(24'd20), .MIN_PERIOD(24'd8), .ACCEL_STEP(24'd4)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .dir_in(dir_in), .steps_in(steps_in),
      .abort(abort), .step_pulse(step_pulse), .dir_out(dir_out), .busy(busy),
      .done(done), .steps_left(steps_left), .cur_period(cur_period)
`ifdef STEP_POS_TRACK_EN
      , .zero_pos(zero_pos), .position(position)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Reference model: walks the move step by step; times are edge numbers after the accept edge.
   int exp_p[$];
   int exp_done;
   int exp_left;

   task automatic compute_expected(input int n, input int abort_at);
      int t, per, ramp, l, ph, tp;
      bit ab;
      exp_p.delete();
      exp_left = -1;
      if (n == 0) begin
         exp_done = 1;
         return;
      end
      t = 0; per = SP; ramp = 0; l = n; ph = 0; ab = 0;
      forever begin
         tp = t + per;
         if (!ab && abort_at > t && abort_at < tp) begin
            l = (l < ramp + 1) ? l : ramp + 1;
            ph = 2; ab = 1; exp_left = l;
         end
         exp_p.push_back(tp);
         l = l - 1;
         if (l == 0) begin
            exp_done = tp + 1;
            return;
         end
         if (ph == 0 && l > ramp) begin
            ramp = ramp + 1;
            if (per - AS <= MP) begin per = MP; ph = 1; end
            else per = per - AS;
         end else if (!(ph == 1 && l > ramp)) begin
            per  = (per + AS > SP) ? SP : per + AS;
            ramp = (ramp > 0) ? ramp - 1 : 0;
            ph   = 2;
         end
         if (!ab && abort_at == tp) begin
            l = (l < ramp + 1) ? l : ramp + 1;
            ph = 2; ab = 1; exp_left = l;
         end
         t = tp;
      end
   endtask

   int last_p[$];
   int last_done;
   int last_left;

   task automatic run_move(input int n, input bit d, input int abort_at);
      int  acc, k, busy0;
      bit  dir_ok;
      compute_expected(n, abort_at);
      last_p.delete();
      last_done = -1;
      last_left = -1;
      dir_ok    = 1'b1;
      busy0     = 0;
      @(negedge clk);
      start = 1'b1; dir_in = d; steps_in = 16'(n); abort = 1'b0;
      @(negedge clk);
      start = 1'b0; acc = cyc;
      dir_in = ~d; steps_in = 16'($urandom_range(1, 60));
      for (int i = 0; i < 2000; i++) begin
         k = cyc - acc;
         if (k == 0) busy0 = int'(busy);
         if (step_pulse) last_p.push_back(k);
         if (k == abort_at) last_left = int'(steps_left);
         if (busy && dir_out != d) dir_ok = 1'b0;
         if (done) begin
            last_done = k;
            break;
         end
         abort = (k + 1 == abort_at);
         start = busy && ($urandom_range(0, 20) == 0);
         if (start) begin
            dir_in   = ~d;
            steps_in = 16'($urandom_range(1, 50));
         end
         @(negedge clk);
      end
      start = 1'b0;
      abort = 1'b0;
      check("busy_after_accept", busy0, (n != 0) ? 1 : 0);
      check("n_pulses", last_p.size(), exp_p.size());
      for (int i = 0; i < last_p.size() && i < exp_p.size(); i++)
         check($sformatf("pulse%0d_time", i), last_p[i], exp_p[i]);
      check("done_time", last_done, exp_done);
      check("busy_at_done", busy, 0);
      check("dir_stable", dir_ok, 1);
      if (exp_left >= 0) check("left_after_abort", last_left, exp_left);
   endtask

   task automatic check_const_pulses(input string tag, input int ref_t[$]);
      check({tag, "_count"}, last_p.size(), ref_t.size());
      for (int i = 0; i < last_p.size() && i < ref_t.size(); i++)
         check($sformatf("%s_p%0d", tag, i), last_p[i], ref_t[i]);
   endtask

   initial begin
      int acc, cnt, nn, ab;
      rst = 1'b0; start = 1'b0; dir_in = 1'b0; steps_in = '0; abort = 1'b0;
`ifdef STEP_POS_TRACK_EN
      zero_pos = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("rst_step_pulse", step_pulse, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_steps_left", steps_left, 0);
      check("rst_cur_period", cur_period, SP);
      check("rst_dir_out", dir_out, 0);
      rst = 1'b1;
      @(negedge clk);

      run_move(10, 1'b1, -1);
      check_const_pulses("m10", '{20, 36, 48, 56, 64, 72, 80, 92, 108, 128});
      check("m10_done", last_done, 129);

      run_move(3, 1'b0, -1);
      check_const_pulses("m3", '{20, 36, 56});
      check("m3_done", last_done, 57);

      run_move(0, 1'b1, -1);
      check("m0_pulses", last_p.size(), 0);
      check("m0_done", last_done, 1);

      run_move(10, 1'b1, 57);
      check_const_pulses("abort", '{20, 36, 48, 56, 64, 76, 92, 112});
      check("abort_left", last_left, 4);
      check("abort_done", last_done, 113);

      // start together with abort in IDLE must not launch a move
      @(negedge clk);
      start = 1'b1; abort = 1'b1; dir_in = 1'b1; steps_in = 16'd5;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (step_pulse || busy || done) cnt++;
         @(negedge clk);
      end
      check("start_abort_idle", cnt, 0);

      for (int r = 0; r < 25; r++) begin
         nn = $urandom_range(0, 25);
         ab = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 400) : -1;
         run_move(nn, 1'($urandom_range(0, 1)), ab);
      end

      // reset between pulses 5 and 6 of a 10-step move
      @(negedge clk);
      start = 1'b1; dir_in = 1'b1; steps_in = 16'd10;
      @(negedge clk);
      start = 1'b0; acc = cyc; cnt = 0;
      for (int i = 0; i < 200 && (cyc - acc) < 68; i++) begin
         if (step_pulse) cnt++;
         @(negedge clk);
      end
      check("pulses_before_rst", cnt, 5);
`ifdef STEP_POS_TRACK_EN
      check("position_before_rst", position, 5);
`endif
      rst = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_steps_left", steps_left, 0);
      check("midrst_cur_period", cur_period, SP);
      check("midrst_dir_out", dir_out, 0);
      check("midrst_step_pulse", step_pulse, 0);
`ifdef STEP_POS_TRACK_EN
      check("position_after_rst", position, 0);
`endif
      @(negedge clk);
      rst = 1'b1;
      cnt = 0;
      for (int i = 0; i < 200; i++) begin
         if (step_pulse || busy || done) cnt++;
         @(negedge clk);
      end
      check("no_pulse_after_rst", cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
